// File: rtl/sram_burst_controller.sv
// sram_burst_controller: turns one mem_req into an 8-byte burst on an asynchronous byte-wide SRAM.
// Define SRAM_BURST_BUSY_EN to add the mem_busy status output.
module sram_burst_controller #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [20:0] mem_address,
    input  logic [7:0]  mem_to_mem,
    input  logic        mem_req,
    input  logic        mem_wren,
    output logic        mem_ready,
    output logic [2:0]  mem_offset,
    output logic [7:0]  mem_from_mem,
`ifdef SRAM_BURST_BUSY_EN
    output logic        mem_busy,
`endif
    output logic [20:0] sram_addr,
    output logic [7:0]  sram_dq_out,
    input  logic [7:0]  sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACCESS,
        S_RD_BEAT,
        S_WR_REQ,
        S_WR_LATCH,
        S_WR_STROBE,
        S_WR_HOLD
    } state_t;

    localparam logic [3:0] LAST_ACC = 4'(ACCESS_CYCLES - 1);

    state_t      state, state_nx;
    logic [17:0] base, base_nx;
    logic [2:0]  beat, beat_nx;
    logic [3:0]  acc_cnt, acc_cnt_nx;

    logic        ready_nx;
    logic [2:0]  offset_nx;
    logic [7:0]  from_mem_nx;
    logic [20:0] addr_nx;
    logic [7:0]  dq_out_nx;
    logic        dq_oe_nx;
    logic        ce_n_nx;
    logic        oe_n_nx;
    logic        we_n_nx;

    // Low address bits select nothing: bursts are always aligned to 8 bytes.
    logic        addr_lsb_unused;
    assign addr_lsb_unused = ^mem_address[2:0];

    always_comb begin
        state_nx    = state;
        base_nx     = base;
        beat_nx     = beat;
        acc_cnt_nx  = acc_cnt;
        from_mem_nx = mem_from_mem;
        dq_out_nx   = sram_dq_out;

        case (state)
            S_IDLE: begin
                if (mem_req) begin
                    base_nx    = mem_address[20:3];
                    beat_nx    = 3'd0;
                    acc_cnt_nx = 4'd0;
                    state_nx   = mem_wren ? S_WR_REQ : S_RD_ACCESS;
                end
            end
            S_RD_ACCESS: begin
                if (acc_cnt == LAST_ACC) begin
                    from_mem_nx = sram_dq_in;
                    state_nx    = S_RD_BEAT;
                end else begin
                    acc_cnt_nx = acc_cnt + 4'd1;
                end
            end
            S_RD_BEAT: begin
                if (beat == 3'd7) begin
                    state_nx = S_IDLE;
                end else begin
                    beat_nx    = beat + 3'd1;
                    acc_cnt_nx = 4'd0;
                    state_nx   = S_RD_ACCESS;
                end
            end
            S_WR_REQ: begin
                state_nx = S_WR_LATCH;
            end
            S_WR_LATCH: begin
                dq_out_nx  = mem_to_mem;
                acc_cnt_nx = 4'd0;
                state_nx   = S_WR_STROBE;
            end
            S_WR_STROBE: begin
                if (acc_cnt == LAST_ACC) begin
                    state_nx = S_WR_HOLD;
                end else begin
                    acc_cnt_nx = acc_cnt + 4'd1;
                end
            end
            S_WR_HOLD: begin
                if (beat == 3'd7) begin
                    state_nx = S_IDLE;
                end else begin
                    beat_nx  = beat + 3'd1;
                    state_nx = S_WR_REQ;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they can be registered alongside it.
    always_comb begin
        ready_nx  = 1'b0;
        offset_nx = mem_offset;
        addr_nx   = sram_addr;
        dq_oe_nx  = 1'b0;
        ce_n_nx   = 1'b1;
        oe_n_nx   = 1'b1;
        we_n_nx   = 1'b1;

        case (state_nx)
            S_RD_ACCESS: begin
                addr_nx = {base_nx, beat_nx};
                ce_n_nx = 1'b0;
                oe_n_nx = 1'b0;
            end
            S_RD_BEAT, S_WR_REQ: begin
                ready_nx  = 1'b1;
                offset_nx = beat_nx;
            end
            S_WR_LATCH: begin
                addr_nx = {base_nx, beat_nx};
                ce_n_nx = 1'b0;
            end
            S_WR_STROBE: begin
                ce_n_nx  = 1'b0;
                we_n_nx  = 1'b0;
                dq_oe_nx = 1'b1;
            end
            S_WR_HOLD: begin
                ce_n_nx  = 1'b0;
                dq_oe_nx = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            base         <= '0;
            beat         <= '0;
            acc_cnt      <= '0;
            mem_ready    <= 1'b0;
            mem_offset   <= '0;
            mem_from_mem <= '0;
            sram_addr    <= '0;
            sram_dq_out  <= '0;
            sram_dq_oe   <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
`ifdef SRAM_BURST_BUSY_EN
            mem_busy     <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            base         <= base_nx;
            beat         <= beat_nx;
            acc_cnt      <= acc_cnt_nx;
            mem_ready    <= ready_nx;
            mem_offset   <= offset_nx;
            mem_from_mem <= from_mem_nx;
            sram_addr    <= addr_nx;
            sram_dq_out  <= dq_out_nx;
            sram_dq_oe   <= dq_oe_nx;
            sram_ce_n    <= ce_n_nx;
            sram_oe_n    <= oe_n_nx;
            sram_we_n    <= we_n_nx;
`ifdef SRAM_BURST_BUSY_EN
            mem_busy     <= (state_nx != S_IDLE);
`endif
        end
    end

endmodule

// File: tb/tb_sram_burst_controller.sv
// Scoreboard bench for sram_burst_controller with a behavioural byte-wide SRAM model.
`timescale 1ns/1ps
module tb_sram_burst_controller;

    localparam int AC = 2;

    typedef struct packed {
        logic       wr;
        logic [2:0] off;
        logic [7:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [20:0] mem_address;
    logic [7:0]  mem_to_mem = 8'h00;
    logic        mem_req;
    logic        mem_wren;
    logic        mem_ready;
    logic [2:0]  mem_offset;
    logic [7:0]  mem_from_mem;
`ifdef SRAM_BURST_BUSY_EN
    logic        mem_busy;
`endif
    logic [20:0] sram_addr;
    logic [7:0]  sram_dq_out;
    logic [7:0]  sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    logic [7:0]  sram_mem [0:2097151];

    beat_t       exp_q[$];
    beat_t       b;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_count = 0;
    int          last_ready_cyc = 0;
    int          we_run = 0;
    int          we_low_cnt = 0;
    logic [20:0] we_addr = '0;
    logic [20:0] cur_base = '0;
    logic [2:0]  cur_off = '0;
    logic        busy_end_pending = 1'b0;

    sram_burst_controller #(.ACCESS_CYCLES(AC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_address  (mem_address),
        .mem_to_mem   (mem_to_mem),
        .mem_req      (mem_req),
        .mem_wren     (mem_wren),
        .mem_ready    (mem_ready),
        .mem_offset   (mem_offset),
        .mem_from_mem (mem_from_mem),
`ifdef SRAM_BURST_BUSY_EN
        .mem_busy     (mem_busy),
`endif
        .sram_addr    (sram_addr),
        .sram_dq_out  (sram_dq_out),
        .sram_dq_in   (sram_dq_in),
        .sram_dq_oe   (sram_dq_oe),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // SRAM write model, protocol monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (!rst_n) begin
            we_run = 0;
            busy_end_pending = 1'b0;
        end else begin
            check("oe_excl", 32'(sram_dq_oe & ~sram_oe_n), 32'd0);
            if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] = sram_dq_out;
            if (!sram_we_n) begin
                we_low_cnt++;
                if (we_run == 0) we_addr = sram_addr;
                else check("we_addr_stable", 32'(sram_addr), 32'(we_addr));
                check("wr_addr", 32'(sram_addr), 32'(cur_base + 21'(cur_off)));
                we_run++;
            end else if (we_run != 0) begin
                check("we_width", 32'(we_run), 32'(AC));
                we_run = 0;
            end
            if (!sram_oe_n && exp_q.size() > 0)
                check("rd_addr", 32'(sram_addr), 32'(cur_base + 21'(exp_q[0].off)));
`ifdef SRAM_BURST_BUSY_EN
            if (busy_end_pending) begin
                check("busy_end", 32'(mem_busy), 32'd0);
                busy_end_pending = 1'b0;
            end
`endif
            if (mem_ready) begin
                ready_count++;
                if (exp_q.size() == 0) begin
                    check("spurious_ready", 32'd1, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    check("offset", 32'(mem_offset), 32'(b.off));
                    if (b.off != 3'd0)
                        check("beat_gap", 32'(cyc - last_ready_cyc), b.wr ? 32'(AC + 3) : 32'(AC + 1));
                    if (b.wr) mem_to_mem = 8'(8'hA0 + 8'(b.off));
                    else check("rd_data", 32'(mem_from_mem), 32'(b.data));
                    cur_off = b.off;
                    last_ready_cyc = cyc;
`ifdef SRAM_BURST_BUSY_EN
                    check("busy_beat", 32'(mem_busy), 32'd1);
                    if (!b.wr && b.off == 3'd7) busy_end_pending = 1'b1;
`endif
                end
            end
        end
    end

    task automatic start_burst(input logic [20:0] addr, input logic wr);
        beat_t e;
        cur_base = {addr[20:3], 3'b000};
        for (int i = 0; i < 8; i++) begin
            e.wr   = wr;
            e.off  = 3'(i);
            e.data = sram_mem[cur_base + 21'(i)];
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        mem_address = addr;
        mem_wren    = wr;
        mem_req     = 1'b1;
        @(posedge clk); #1;
        mem_req     = 1'b0;
    endtask

    task automatic wait_ready(input int target, input int budget);
        int n = 0;
        while (ready_count < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("beats_done", 32'(ready_count), 32'(target));
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_offset", 32'(mem_offset), 32'd0);
        check("rst_from_mem", 32'(mem_from_mem), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
`ifdef SRAM_BURST_BUSY_EN
        check("rst_busy", 32'(mem_busy), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int we0;
        rst_n       = 1'b0;
        mem_req     = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        for (int i = 0; i < 8; i++) begin
            sram_mem[32'h0000A8 + i] = 8'(8'h10 + i);
            sram_mem[32'h000010 + i] = 8'(8'h50 + i);
            sram_mem[32'h1FFFF8 + i] = 8'h33;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a read beat, checked before any clock edge.
        rc0 = ready_count;
        start_burst(21'h0000A8, 1'b0);
        wait_ready(rc0 + 2, 50);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_resume_rd", 32'(ready_count), 32'(rc0 + 2));

        // Full read burst from an aligned base.
        rc0 = ready_count;
        we0 = we_low_cnt;
        start_burst(21'h0000A8, 1'b0);
        wait_ready(rc0 + 8, 100);
        repeat (10) @(negedge clk);
        check("rd_no_we", 32'(we_low_cnt - we0), 32'd0);
        check("rd_q_empty", 32'(exp_q.size()), 32'd0);

        // Full write burst at the top of the address space.
        rc0 = ready_count;
        start_burst(21'h1FFFF8, 1'b1);
        wait_ready(rc0 + 8, 200);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++)
            check("wr_mem", 32'(sram_mem[32'h1FFFF8 + i]), 32'(8'hA0 + i));
        check("wr_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset during the third write strobe.
        for (int i = 0; i < 8; i++) sram_mem[32'h1FFFF8 + i] = 8'h33;
        rc0 = ready_count;
        start_burst(21'h1FFFF8, 1'b1);
        wait_ready(rc0 + 3, 100);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check_reset_outputs();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_resume_wr", 32'(ready_count), 32'(rc0 + 3));
        check("abort_mem0", 32'(sram_mem[32'h1FFFF8]), 32'hA0);
        check("abort_mem1", 32'(sram_mem[32'h1FFFF9]), 32'hA1);
        for (int i = 3; i < 8; i++)
            check("abort_untouched", 32'(sram_mem[32'h1FFFF8 + i]), 32'h33);

        // Unaligned address: low bits ignored, burst restarts at offset 0.
        rc0 = ready_count;
        start_burst(21'h000013, 1'b0);
        wait_ready(rc0 + 8, 100);
        repeat (10) @(negedge clk);
        check("unal_q_empty", 32'(exp_q.size()), 32'd0);

        // A second request while busy must be ignored.
        rc0 = ready_count;
        we0 = we_low_cnt;
`ifdef SRAM_BURST_BUSY_EN
        check("busy_idle", 32'(mem_busy), 32'd0);
`endif
        start_burst(21'h0000A8, 1'b0);
`ifdef SRAM_BURST_BUSY_EN
        check("busy_accept", 32'(mem_busy), 32'd1);
`endif
        repeat (3) @(posedge clk);
        #1;
        mem_address = 21'h1FFFF8;
        mem_wren    = 1'b1;
        mem_req     = 1'b1;
        @(posedge clk); #1;
        mem_req     = 1'b0;
        mem_wren    = 1'b0;
        wait_ready(rc0 + 8, 100);
        repeat (20) @(negedge clk);
        check("ignored_req_beats", 32'(ready_count), 32'(rc0 + 8));
        check("ignored_req_no_we", 32'(we_low_cnt - we0), 32'd0);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_burst_controller.md
SRAM_BURST_CONTROLLER -- requirements
Module: sram_burst_controller

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, meaning SRAM strobe width per byte in clk cycles (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_address  input  21  burst byte address; bits [2:0] ignored.
REQ-005 SHALL have port mem_to_mem  input  8  write byte, valid the cycle after each write-beat mem_ready.
REQ-006 SHALL have port mem_req  input  1  one-cycle burst request pulse.
REQ-007 SHALL have port mem_wren  input  1  burst direction, 1=write, sampled with mem_req.
REQ-008 SHALL have ports mem_ready (output, 1, beat strobe), mem_offset (output, 3, beat index) and mem_from_mem (output, 8, read byte).
REQ-009 SHALL have port sram_addr  output  21  SRAM byte address.
REQ-010 SHALL have ports sram_dq_out (output, 8), sram_dq_in (input, 8) and sram_dq_oe (output, 1, 1 = FPGA drives bus).
REQ-011 SHALL have ports sram_ce_n, sram_oe_n and sram_we_n, each output, 1, active-low SRAM strobes.

Function
REQ-012 SHALL register every output; no combinational input-to-output path.
REQ-013 SHALL accept mem_req only in S_IDLE, latching base=mem_address[20:3], wren and beat k=0; mem_req in any other state SHALL be ignored.
REQ-014 SHALL perform each burst as exactly 8 byte accesses at {base,k}, k=0..7 ascending, with no wrap beyond base*8+7.
REQ-015 SHALL, in S_RD_ACCESS, drive sram_addr={base,k}, sram_ce_n=0, sram_oe_n=0, sram_dq_oe=0 for ACCESS_CYCLES cycles and capture sram_dq_in on the last one.
REQ-016 SHALL, in S_RD_BEAT (1 cycle), assert mem_ready=1, mem_offset=k and mem_from_mem=captured byte, then go to S_IDLE if k=7, else increment k and go to S_RD_ACCESS.
REQ-017 SHALL hold mem_from_mem at its last value outside S_RD_BEAT.
REQ-018 SHALL space read beats ACCESS_CYCLES+1 cycles apart.
REQ-019 SHALL, in S_WR_REQ (1 cycle), assert mem_ready=1 with mem_offset=k, requesting byte k.
REQ-020 SHALL, in S_WR_LATCH (1 cycle), capture mem_to_mem and drive sram_addr={base,k}, sram_ce_n=0 and sram_we_n=1.
REQ-021 SHALL, in S_WR_STROBE, drive sram_dq_out=captured byte, sram_dq_oe=1 and sram_we_n=0 for ACCESS_CYCLES cycles, keeping address stable.
REQ-022 SHALL, in S_WR_HOLD (1 cycle), drive sram_we_n=1 with address, data and sram_dq_oe held, then go to S_IDLE if k=7, else increment k and go to S_WR_REQ.
REQ-023 SHALL space write beats ACCESS_CYCLES+3 cycles apart.
REQ-024 SHALL keep sram_oe_n=1 whenever sram_dq_oe=1, and sram_dq_oe=0 whenever sram_oe_n=0.
REQ-025 SHALL drive sram_ce_n=1, sram_oe_n=1 and sram_we_n=1 in S_IDLE.
REQ-026 SHALL assert mem_ready for exactly one cycle per beat, 8 pulses per burst.
REQ-027 SHALL leave S_IDLE on the cycle after mem_req is sampled.

Reset
REQ-028 SHALL, on rst_n low, immediately force state S_IDLE, k=0, mem_ready=0, mem_offset=0, mem_from_mem=0x00, sram_addr=0, sram_dq_out=0x00, sram_dq_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, even mid-burst.
REQ-029 SHALL discard any aborted burst and neither resume nor complete it after reset release.

Configuration
REQ-030 SHALL, with SRAM_BURST_BUSY_EN defined, add output mem_busy (1 bit, reset 0), =1 in every state except S_IDLE; without the macro, the port and its logic SHALL be absent and all other behaviour identical.

Verification (ACCESS_CYCLES=2)
REQ-031 SHALL cover: reset asserted mid-clock -> all outputs at the REQ-028 values with no clock edge required.
REQ-032 SHALL cover: SRAM model holds 0x10..0x17 at 0x0000A8..0x0000AF; read mem_address=0x0000A8 -> 8 mem_ready pulses 3 cycles apart, offsets 0..7, data 0x10..0x17; sram_we_n stays 1.
REQ-033 SHALL cover: write mem_address=0x1FFFF8, bench returns 0xA0+offset the cycle after each ready -> SRAM 0x1FFFF8..0x1FFFFF = 0xA0..0xA7; each sram_we_n low exactly 2 cycles; address stable across low.
REQ-034 SHALL cover: read mem_address=0x000013 -> SRAM addresses 0x000010..0x000017 accessed.
REQ-035 SHALL cover: rst_n low after 3rd write beat -> sram_we_n=1, sram_dq_oe=0 at once; SRAM 0x1FFFFB..0x1FFFFF unchanged; next read burst starts at offset 0.
REQ-036 SHALL cover: with SRAM_BURST_BUSY_EN, mem_req pulsed during busy read -> ignored, exactly 8 ready pulses; mem_busy 1 from cycle after accept until return to S_IDLE.
